// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory write arbiters.
package mem_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Next round-robin position after idx, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first asserted request found by
// scanning from rr_ptr upward, wrapping modulo NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 4,
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               found,
   output logic [ID_W-1:0]    winner
);

   int idx;

   // Scan from the farthest offset down to the nearest so that the nearest
   // asserted request is the last one written.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (req[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM write master between NUM_REQ
// writers. The granted writer passes straight through; the grant is held
// across waitrequest stalls and rotates after QUANTUM accepted writes or
// when the writer drops its write strobe.
//
//   state | meaning
//   IDLE  | no grant; arbitrate among requesters when enable is high
//   GRANT | grant_id owns the memory port
module mem_write_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int WRITE_WIDTH   = 256,
   parameter int ADDRESS_WIDTH = 32,
   parameter int QUANTUM       = 4,
   localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int QC_W  = $clog2(QUANTUM + 1)
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               enable,
   input  logic [NUM_REQ-1:0]                 req_write,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_address,
   input  logic [NUM_REQ*WRITE_WIDTH-1:0]     req_writedata,
   output logic [NUM_REQ-1:0]                 req_waitrequest,
   output logic                               mem_write,
   output logic [ADDRESS_WIDTH-1:0]           mem_address,
   output logic [WRITE_WIDTH-1:0]             mem_writedata,
   input  logic                               mem_waitrequest,
   output logic                               grant_valid,
   output logic [GID_W-1:0]                   grant_id
);

   arb_state_e               state, state_nxt;
   logic [GID_W-1:0]         grant_id_nxt;
   logic [GID_W-1:0]         rr_ptr, rr_ptr_nxt;
   logic [QC_W-1:0]          qcount, qcount_nxt;
   logic                     pick_found;
   logic [GID_W-1:0]         pick_id;
   logic                     sel_write;
   logic [ADDRESS_WIDTH-1:0] sel_address;
   logic [WRITE_WIDTH-1:0]   sel_writedata;
   logic                     accept;
   logic                     last_write;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req    (req_write),
      .rr_ptr (rr_ptr),
      .found  (pick_found),
      .winner (pick_id)
   );

   // Arbiter state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         qcount   <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_id_nxt;
         rr_ptr   <= rr_ptr_nxt;
         qcount   <= qcount_nxt;
      end
   end

   // Pass-through mux from the granted requester to memory; zero when idle.
   always_comb begin
      sel_write       = req_write[grant_id];
      sel_address     = req_address[grant_id*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      sel_writedata   = req_writedata[grant_id*WRITE_WIDTH +: WRITE_WIDTH];
      grant_valid     = (state == GRANT);
      mem_write       = grant_valid && sel_write;
      mem_address     = mem_write ? sel_address : '0;
      mem_writedata   = mem_write ? sel_writedata : '0;
      req_waitrequest = '1;
      if (grant_valid) req_waitrequest[grant_id] = mem_waitrequest;
      accept          = mem_write && !mem_waitrequest;
      last_write      = accept && ((qcount + QC_W'(1)) == QC_W'(QUANTUM));
   end

   // Grant/rotate decisions. Release only on an accepted write or a dropped
   // strobe, so a stalled command never loses its grant.
   always_comb begin
      state_nxt    = state;
      grant_id_nxt = grant_id;
      rr_ptr_nxt   = rr_ptr;
      qcount_nxt   = qcount;
      case (state)
         IDLE: begin
            if (enable && pick_found) begin
               state_nxt    = GRANT;
               grant_id_nxt = pick_id;
               qcount_nxt   = '0;
            end
         end
         GRANT: begin
            if (accept) qcount_nxt = qcount + QC_W'(1);
            if (!sel_write || last_write) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = GID_W'(rr_next(int'(grant_id), NUM_REQ));
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/mem_write_arbiter.md
# mem_write_arbiter

Round-robin arbiter that shares one Avalon-MM write master port between NUM_REQ stream-to-memory writers (write/address/writedata/waitrequest masters). It sits between the writer instances and the memory interconnect. It grants one requester at a time and holds the grant stable across waitrequest stalls. A per-grant quantum bounds how many consecutive writes one requester may issue before the arbiter rotates.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WRITE_WIDTH, 256, write data width
- ADDRESS_WIDTH, 32, address width
- QUANTUM, 4, max accepted writes per grant (>=1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = new grants allowed; 0 = finish current grant, issue no new ones
- req_write  in  NUM_REQ  per-requester write strobe
- req_address  in  NUM_REQ x ADDRESS_WIDTH  per-requester address
- req_writedata  in  NUM_REQ x WRITE_WIDTH  per-requester data
- req_waitrequest  out  NUM_REQ  per-requester stall; 1 unless granted and memory not stalling
- mem_write  out  1  write strobe to memory
- mem_address  out  ADDRESS_WIDTH  muxed address; '0 when mem_write=0
- mem_writedata  out  WRITE_WIDTH  muxed data; '0 when mem_write=0
- mem_waitrequest  in  1  memory stall
- grant_valid  out  1  1 in GRANT state
- grant_id  out  $clog2(NUM_REQ)  currently/last granted requester

## Operation
- States: IDLE, GRANT. Registers: state, grant_id, rr_ptr, qcount ($clog2(QUANTUM+1) bits).
- Reset: state=IDLE, grant_id=0, rr_ptr=0, qcount=0. Outputs: mem_write=0, mem_address='0, mem_writedata='0, req_waitrequest=all 1, grant_valid=0.
- IDLE: if enable && |req_write: winner = first asserted index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. Register grant_id=winner, qcount=0, go GRANT. Otherwise stay.
- GRANT: mem_write=req_write[grant_id], mem_address/mem_writedata=req_*[grant_id] (gated to '0 when write low). req_waitrequest[grant_id]=mem_waitrequest; all others 1.
- Accept = mem_write && !mem_waitrequest; qcount increments on accept.
- Leave GRANT for IDLE (rr_ptr = grant_id+1 mod NUM_REQ) when:
  - accept occurs and qcount+1 == QUANTUM; or
  - req_write[grant_id]==0 for a cycle.
- Otherwise stay in GRANT.
- Grant never changes while mem_write && mem_waitrequest (Avalon command stability).
- enable deassert: no effect on an active grant. It blocks only the IDLE→GRANT transition.

## Timing
- Arbitration latency: req_write rising with the arbiter in IDLE → mem_write high the next cycle. Requester sees waitrequest=1 in the arbitration cycle.
- Back-to-back: release to IDLE costs one cycle before the next grant. A single-write requester occupies 3 cycles minimum (IDLE, GRANT-accept, GRANT-release).
- Writes from the granted requester pass through combinationally: no added latency and no buffering.
- Simultaneous requests: lowest index at or after rr_ptr wins. The last winner becomes lowest priority.
- Requester dropping write while stalled violates the protocol; the arbiter releases the grant without error flag.
- NUM_REQ=1: rr_ptr stays 0; same state sequence.
- Reset mid-GRANT: outputs go to reset values immediately (async). In-flight write is abandoned.

## Structure
- Package mem_arb_pkg: state enum (IDLE, GRANT), helper function for the round-robin pointer increment modulo NUM_REQ.
- Sub-module rr_picker: combinational. Inputs are the request vector and rr_ptr; outputs are a found flag and the winner index. It is reused by later arbiters.
- Top module contains the state register, qcount, and the output muxes.

## Test plan
- Single requester: req_write[2]=1, address 0x100, mem_waitrequest=0 → mem_write one cycle later with address 0x100. req_waitrequest[2]=0 on that cycle; rr_ptr becomes 3 after release.
- Stall hold: grant requester 1, mem_waitrequest=1 for 5 cycles while req_write[0] also asserted → grant_id stays 1. mem_address is stable and req_waitrequest[0]=1 throughout.
- Fairness: all 4 requesters write continuously, QUANTUM=4 → grants in order 0,1,2,3,0. Exactly 4 accepts per grant.
- Quantum=1 with continuous requests from 0 and 3 → accepts alternate 0,3,0,3.
- Drain: deassert enable during grant of requester 2 → its pending writes complete. No new grant_valid while enable=0; re-enable → next grant is 3 if requesting.
- Async reset asserted mid-stall → mem_write=0, req_waitrequest=4'b1111, grant_id=0 without waiting for a clock edge.
